// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the MEM stage and its responder.
// The err signal exists only when DMEM_BOUNDS_EN is defined.
interface dmem_if;
   logic [15:0] addr;
   logic        re;
   logic        we;
   logic [15:0] wrt_data;
   logic [15:0] rd_data;
   logic        rdy;
   logic        stall;
`ifdef DMEM_BOUNDS_EN
   logic        err;
`endif

   modport master (
      output addr, re, we, wrt_data,
      input  rd_data, rdy, stall
`ifdef DMEM_BOUNDS_EN
      , input err
`endif
   );

   modport slave (
      input  addr, re, we, wrt_data,
      output rd_data, rdy, stall
`ifdef DMEM_BOUNDS_EN
      , output err
`endif
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: completes one access LATENCY cycles after acceptance.
// Optional DMEM_BOUNDS_EN flags out-of-range addresses (err, no write, reads 16'hDEAD).
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          cnt;
   logic [3:0]          cnt_nxt;
   logic                req;
   logic                enter_done;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [15:0]         lat_data;
   logic                cur_we;
   logic [ADDR_W-1:0]   cur_addr;
   logic [15:0]         cur_data;
   logic                cur_oor;
   logic [15:0]         mem [2**ADDR_W];

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 1..15");
   end

   assign req = bus.re | bus.we;

   // With LATENCY==1 the commit edge is the acceptance edge, so use live inputs in IDLE.
   assign cur_we   = (state == IDLE) ? bus.we                   : lat_we;
   assign cur_addr = (state == IDLE) ? bus.addr[ADDR_W-1:0]     : lat_addr;
   assign cur_data = (state == IDLE) ? bus.wrt_data             : lat_data;

`ifdef DMEM_BOUNDS_EN
   logic lat_oor;
   assign cur_oor = (state == IDLE) ? (|bus.addr[15:ADDR_W]) : lat_oor;
   assign bus.err = (state == DONE) & lat_oor;
`else
   logic unused_hi;
   assign unused_hi = |bus.addr[15:ADDR_W];
   assign cur_oor   = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               cnt_nxt   = 4'(LATENCY - 1);
               state_nxt = (LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign enter_done = (state_nxt == DONE) && (state != DONE);
   assign bus.rdy    = (state == DONE);
   assign bus.stall  = req & ~bus.rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         bus.rd_data <= 16'h0000;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_data    <= 16'h0000;
`ifdef DMEM_BOUNDS_EN
         lat_oor     <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            lat_we   <= bus.we;
            lat_addr <= bus.addr[ADDR_W-1:0];
            lat_data <= bus.wrt_data;
`ifdef DMEM_BOUNDS_EN
            lat_oor  <= |bus.addr[15:ADDR_W];
`endif
         end
         if (enter_done && !cur_we)
            bus.rd_data <= cur_oor ? 16'hDEAD : mem[cur_addr];
      end
   end

   // Array is deliberately left out of reset; a reset on the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (!rst && enter_done && cur_we && !cur_oor)
         mem[cur_addr] <= cur_data;
   end

endmodule
